// File: rtl/apb_target_mem.sv
// APB responder with a byte-wide local memory, programmable wait states, a
// read-only upper window and error responses; acts as a DMA source/destination.
module apb_target_mem #(
    parameter int DEPTH   = 64,
    parameter int RO_BASE = 48
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       perr,
    input  logic [1:0] wait_cfg,
    output logic [7:0] err_count
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);
    localparam logic [7:0] RO_C    = 8'(RO_BASE);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [6:0] addr_q, addr_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic [7:0] rd_q, rd_d;
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;
    logic [7:0] mem_q [DEPTH];

    logic       latch_s, err_inc_s, mem_we_s, rd_en_s, pready_s, perr_s;
    logic [6:0] set_addr_s;
    logic       set_in_rng_s, set_err_s;
    logic [7:0] set_rd_s;

    // Decode of the address presented in a setup phase.
    always_comb begin
        set_addr_s   = paddr[6:0];
        set_in_rng_s = ({1'b0, set_addr_s} < DEPTH_C);
        set_err_s    = ~set_in_rng_s | (pwrite & ({1'b0, set_addr_s} >= RO_C));
        if (set_in_rng_s) begin
            set_rd_s = mem_q[set_addr_s[AW-1:0]];
        end else begin
            set_rd_s = 8'h00;
        end
    end

    // Transfer FSM: next state, response and side-effect strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rd_d      = rd_q;
        err_d     = err_q;
        latch_s   = 1'b0;
        err_inc_s = 1'b0;
        mem_we_s  = 1'b0;
        rd_en_s   = 1'b0;
        pready_s  = 1'b0;
        perr_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    latch_s = 1'b1;
                    state_d = ST_ACCESS;
                end else if (psel && penable) begin
                    // access phase without a setup phase: answer with an error at once
                    pready_s  = 1'b1;
                    perr_s    = 1'b1;
                    err_inc_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (!penable) begin
                    latch_s = 1'b1;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    pready_s  = 1'b1;
                    perr_s    = err_q;
                    err_inc_s = err_q;
                    mem_we_s  = pwrite_q & ~err_q;
                    rd_en_s   = ~pwrite_q & ~err_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (latch_s) begin
            addr_d   = set_addr_s;
            pwrite_d = pwrite;
            pwdata_d = pwdata;
            cnt_d    = wait_cfg;
            rd_d     = set_rd_s;
            err_d    = set_err_s;
        end else begin
            addr_d = addr_q;
        end
        if (err_inc_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Control and transfer-context registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            addr_q      <= 7'd0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 8'h00;
            rd_q        <= 8'h00;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Byte storage, written only on a completing error-free write.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            mem_q[addr_q[AW-1:0]] <= pwdata_q;
        end
    end

    assign pready    = nrst & pready_s;
    assign perr      = nrst & perr_s;
    assign prdata    = (nrst && rd_en_s) ? rd_q : 8'h00;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_apb_target_mem.sv
// Randomized bench for apb_target_mem: a transfer-level model predicts every
// cycle's pready/perr/prdata/err_count, plus a few literal expectations.
module tb_apb_target_mem;
    logic       clk = 1'b0;
    logic       nrst, psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata, err_count;
    logic       pready, perr;
    logic [1:0] wait_cfg;

    int checks = 0;
    int errors = 0;

    logic       exp_pready, exp_perr;
    logic [7:0] exp_prdata;
    logic [7:0] mem_m [64];
    int         err_cnt_m;
    logic [7:0] last_rdata;
    logic       last_perr, last_pready;

    apb_target_mem #(.DEPTH(64), .RO_BASE(48)) dut (
        .clk(clk), .nrst(nrst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .perr(perr), .wait_cfg(wait_cfg), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("pready", int'(pready), int'(exp_pready));
        check("perr", int'(perr), int'(exp_perr));
        check("prdata", int'(prdata), int'(exp_prdata));
        check("err_count", int'(err_count), err_cnt_m);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
        err_cnt_m = 0;
    endtask

    task automatic err_bump();
        if (err_cnt_m < 255) err_cnt_m++;
    endtask

    task automatic set_exp_zero();
        exp_pready = 1'b0;
        exp_perr   = 1'b0;
        exp_prdata = 8'h00;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            psel    = 1'b0;
            penable = 1'b0;
            set_exp_zero();
            tick();
        end
    endtask

    // One transfer; stop_at >= 0 leaves after that many access cycles, unfinished.
    task automatic xfer(bit wr, logic [7:0] addr, logic [7:0] data, int waits, int stop_at);
        int a;
        bit err;
        a   = int'(addr[6:0]);
        err = (a >= 64) || (wr && a >= 48);
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = data;
        wait_cfg = 2'(waits);
        set_exp_zero();
        tick();
        wait_cfg = 2'($urandom);
        pwdata   = 8'($urandom);
        for (int k = 0; k <= waits; k++) begin
            if (k == stop_at) return;
            penable    = 1'b1;
            exp_pready = (k == waits);
            exp_perr   = exp_pready && err;
            exp_prdata = (exp_pready && !wr && !err) ? mem_m[a] : 8'h00;
            #1;
            if (k == waits) begin
                last_rdata  = prdata;
                last_perr   = perr;
                last_pready = pready;
            end
            tick();
            if (k == waits) begin
                if (err) err_bump();
                else if (wr) mem_m[a] = data;
            end
        end
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic violation();
        psel       = 1'b1;
        penable    = 1'b1;
        pwrite     = 1'($urandom);
        paddr      = 8'($urandom);
        exp_pready = 1'b1;
        exp_perr   = 1'b1;
        exp_prdata = 8'h00;
        tick();
        err_bump();
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] v;
        case ($urandom_range(0, 2))
            0:       v = 8'($urandom_range(0, 15));
            1:       v = 8'($urandom_range(40, 71));
            default: v = 8'($urandom_range(0, 127));
        endcase
        v[7] = 1'($urandom);
        return v;
    endfunction

    initial begin
        bit         wr;
        logic [7:0] addr;
        int         waits, r;
        nrst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; wait_cfg = 2'd0;
        model_reset();
        set_exp_zero();
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        idle(2);
        check("rst_err_count_lit", int'(err_count), 0);
        check("rst_pready_lit", int'(pready), 0);

        xfer(1'b1, 8'h05, 8'hA5, 0, -1);
        xfer(1'b0, 8'h05, 8'h00, 0, -1);
        check("rd05_data_lit", int'(last_rdata), 8'hA5);
        check("rd05_perr_lit", int'(last_perr), 0);
        xfer(1'b0, 8'h85, 8'h00, 3, -1);
        check("rd85_wait3_lit", int'(last_rdata), 8'hA5);

        xfer(1'b0, 8'h40, 8'h00, 0, -1);
        check("oor_perr_lit", int'(last_perr), 1);
        check("oor_prdata_lit", int'(last_rdata), 0);
        xfer(1'b1, 8'h31, 8'h77, 1, -1);
        check("ro_perr_lit", int'(last_perr), 1);
        idle(1);
        check("errcnt2_lit", int'(err_count), 2);
        xfer(1'b0, 8'h31, 8'h00, 0, -1);
        check("ro_unchanged_lit", int'(last_rdata), 0);

        xfer(1'b1, 8'h10, 8'h5A, 2, 1);
        idle(1);
        xfer(1'b0, 8'h10, 8'h00, 0, -1);
        check("abandon_lit", int'(last_rdata), 0);
        xfer(1'b1, 8'h06, 8'h11, 2, 1);
        xfer(1'b0, 8'h06, 8'h00, 1, -1);
        check("resetup_lit", int'(last_rdata), 0);
        violation();
        idle(1);
        check("violation_cnt_lit", int'(err_count), 3);

        for (int n = 0; n < 300; n++) begin
            r     = $urandom_range(0, 9);
            wr    = 1'($urandom);
            addr  = rand_addr();
            waits = $urandom_range(0, 3);
            if (r == 0) begin
                violation();
            end else if (r == 1) begin
                xfer(wr, addr, 8'($urandom), waits, $urandom_range(0, waits));
                idle(1);
            end else if (r == 2) begin
                xfer(wr, addr, 8'($urandom), waits, $urandom_range(0, waits));
                xfer(1'($urandom), rand_addr(), 8'($urandom), $urandom_range(0, 3), -1);
            end else begin
                xfer(wr, addr, 8'($urandom), waits, -1);
            end
            idle($urandom_range(0, 1));
        end

        xfer(1'b1, 8'h20, 8'h3C, 0, -1);
        xfer(1'b1, 8'h20, 8'hCC, 2, 1);
        psel    = 1'b1;
        penable = 1'b1;
        nrst    = 1'b0;
        model_reset();
        set_exp_zero();
        #1;
        check("rst_mid_pready_lit", int'(pready), 0);
        check("rst_mid_errcnt_lit", int'(err_count), 0);
        tick();
        nrst = 1'b1;
        idle(1);
        xfer(1'b0, 8'h20, 8'h00, 0, -1);
        check("rst_mid_discard_lit", int'(last_rdata), 0);

        for (int n = 0; n < 256; n++) begin
            addr    = 8'($urandom_range(64, 127));
            addr[7] = 1'($urandom);
            xfer(1'b0, addr, 8'h00, 0, -1);
        end
        idle(2);
        check("errcnt_sat_lit", int'(err_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_target_mem.md
# apb_target_mem

APB target with a byte-wide local memory, programmable wait states and error response: the responder end of the DMA APB master's `pselN`/`penable`/`pready` bus. One instance hangs off each of the master's `psel0`/`psel1` ports and serves as a DMA source or destination. It gives the DMA path a realistic, verifiable peer: reads, writes, stalls and errors.

## Interface
- `DEPTH`, default 64: number of byte locations. Legal range 1..128.
- `RO_BASE`, default 48: locations `RO_BASE..DEPTH-1` are read-only. Setting `RO_BASE = DEPTH` disables read-only protection.
- `clk`  in  1: single clock. Everything is on its rising edge.
- `nrst`  in  1: reset, asynchronous and active-low.
- `psel`  in  1: target select.
- `penable`  in  1: access phase.
- `pwrite`  in  1: 1 = write, 0 = read.
- `paddr`  in  8: byte address. Only `paddr[6:0]` is decoded; bit 7 is ignored (it is the master's device select).
- `pwdata`  in  8: write data.
- `prdata`  out  8: read data. Valid only while `pready` is 1; otherwise 0.
- `pready`  out  1: transfer complete.
- `perr`  out  1: error response. Asserted only together with `pready`.
- `wait_cfg`  in  2: number of wait states (0..3) to insert. Sampled in the setup cycle.
- `err_count`  out  8: count of error responses, saturating at 255.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE, `psel=1`, `penable=0` (setup phase). On this edge the block latches:
  - address `a = paddr[6:0]`, plus `pwrite` and `pwdata`;
  - `cnt <= wait_cfg`;
  - `rd_q <= (a < DEPTH) ? mem[a] : 0`;
  - error flag `e = (a >= DEPTH) | (pwrite & a >= RO_BASE & a < DEPTH)`;
  - next state is ACCESS.
- IDLE, `psel=1`, `penable=1` (access with no setup phase, a protocol violation):
  - drive `pready=1`, `perr=1` combinationally in that cycle;
  - no memory effect; `err_count` increments; FSM stays in IDLE.
- ACCESS:
  - `pready = psel & penable & (cnt == 0)`;
  - while `cnt != 0`, decrement `cnt` each edge.
- Completing edge (`pready=1`):
  - if `pwrite & !e`, then `mem[a] <= latched pwdata`;
  - if `e`, then `perr=1` and `err_count` increments, with no memory change;
  - next state is IDLE.
- `prdata = rd_q` when `pready & !pwrite_latched & !e`; 0 otherwise, including during error responses.
- ACCESS with `psel=0` means the master abandoned the transfer: return to IDLE with no memory write, no error, and no count change.
- ACCESS with `psel=1`, `penable=0` (re-setup without completing): treat as a new setup phase and re-latch everything. The old transfer is dropped.
- `err_count` saturates at 255 and stays there until reset.

## Timing
- Reset (async assert, synchronous-safe deassert) values:
  - FSM = IDLE, `cnt = 0`, `rd_q = 0`, `err_count = 0`, all `mem` locations = 0;
  - `pready = 0`, `perr = 0`, `prdata = 0`.
- Zero-wait transfer: setup in cycle T, `pready=1` in cycle T+1.
- Wait states: with `wait_cfg = n`, `pready=1` in cycle T+1+n, with exactly n low-`pready` access cycles before it.
- A write is visible to a read whose setup cycle is at or after the cycle following the write's completing cycle. This covers back-to-back transfers: the master's next setup comes immediately after the completing cycle.
- `pready`/`perr`/`prdata` are combinational from registered state plus `psel`/`penable`. There is no other comb path from inputs to outputs.
- `wait_cfg` changes outside the setup cycle have no effect on a transfer in flight.
- Reset mid-transfer: outputs drop to reset values immediately, and the pending write is discarded.

## Test plan
- Write `0xA5` to address `0x05`, then read `0x05`, with `wait_cfg=0` → `pready` one cycle after each setup; the read returns `prdata=0xA5`, `perr=0`.
- `wait_cfg=3`, read address `0x85` after the previous test → 3 cycles of `pready=0`, then `pready=1`, `prdata=0xA5` (bit 7 ignored).
- Read address `0x40` (DEPTH 64); write `0x31` (≥ RO_BASE) with data `0x77` → both responses have `perr=1`, `prdata=0`; `mem[0x31]` stays 0; `err_count=2`.
- Setup a write to `0x10` with `wait_cfg=2`, then drop `psel` in the first access cycle → no `pready`, `mem[0x10]` unchanged, FSM in IDLE. A following normal read of `0x10` returns 0.
- Assert `nrst=0` mid-access of a write to `0x20` → outputs are 0 in the same cycle; after release, a read of `0x20` returns 0 and `err_count=0`.
- 256 consecutive out-of-range reads → `err_count` reaches 255 and holds there.
